mips_dmem_responder: RTL and testbench
======================================

// Module: mips_dmem_responder
// PURPOSE
//  Memory-side responder for the pipelined MIPS core's load/store port. Accepts one word request at a
//  time via valid/response handshake, serves it from an internal word RAM or a memory-mapped I/O window
//  (PortOut register, PortIn input), and raises stall while a request is pending.
//  Sits between the core's M stage and the board pins; it replaces the zero-latency data RAM.
// PARAMETERS
//  MEMORY_DEPTH  1024  RAM size in 32-bit words; power of 2, >= 2.
//  WAIT_STATES   2     extra cycles between request accept and response; 0..15.
// PORTS
//  clk         in   1   rising-edge clock
//  reset       in   1   asynchronous, active-high reset
//  req_valid   in   1   request present; held stable until resp_valid
//  req_write   in   1   1 = store word, 0 = load word
//  req_addr    in   32  byte address; bits [1:0] ignored
//  req_wdata   in   32  store data
//  resp_valid  out  1   one-cycle pulse: request complete
//  resp_rdata  out  32  load data, valid while resp_valid = 1
//  stall       out  1   req_valid & ~resp_valid (combinational); core freezes PC and pipeline registers
//  PortIn      in   8   external input pins
//  PortOut     out  32  memory-mapped output register
// BEHAVIOUR
//  - Reset (async, active-high): state=IDLE, resp_valid=0, resp_rdata=0, PortOut=0, wait counter=0.
//    RAM contents are not cleared. A reset during WAIT aborts the request; a pending store is discarded.
//  - Decode on latched address: req_addr[31:28]==4'h1 -> I/O window, otherwise RAM.
//    RAM index = req_addr[log2(MEMORY_DEPTH)+1:2]; higher bits ignored (wraps modulo depth).
//    I/O: 0x1000_0000 = PortOut (R/W); 0x1000_0004 = PortIn (RO, zero-extended to 32 bits;
//    stores ignored); other I/O offsets read 0, stores ignored.
//  - FSM IDLE -> WAIT -> RESP -> IDLE.
//    IDLE: on req_valid at edge T, latch addr/wdata/write; cnt<=WAIT_STATES;
//      next = WAIT if WAIT_STATES>0 else RESP.
//    WAIT: cnt decrements each cycle; when cnt==1 next = RESP.
//    Entering RESP: store commits (RAM word or PortOut); load result is registered into resp_rdata.
//    RESP: resp_valid=1 for exactly one cycle; next = IDLE unconditionally (no request accepted in RESP).
//  - Latency: resp_valid high in cycle T+1+WAIT_STATES; throughput one request per 2+WAIT_STATES cycles.
//  - resp_rdata holds its last value outside RESP; store responses return resp_rdata = 0.
//  - req_valid dropping before resp_valid is a protocol violation; the responder still completes the
//    latched request.
//  - Load of PortOut returns its current value; load-after-store to the same address returns the new data.
// CONFIGURATION
//  MIPS_DMEM_PORTIN_SYNC_EN defined: PortIn passes through a two-flop synchronizer (reset to 0).
//    Reads of 0x1000_0004 see pin changes 2 cycles late.
//  Not defined: PortIn is sampled directly when entering RESP. No other behaviour changes.
// TESTING
//  1. Reset, WAIT_STATES=2: store 0xDEADBEEF to 0x0000_0010 at T -> resp_valid only at T+3;
//     stall high T..T+2; load 0x10 -> 0xDEADBEEF.
//  2. Store 0x0000_00A5 to 0x1000_0000 -> PortOut=0x000000A5 from the RESP cycle on;
//     load 0x1000_0000 -> 0xA5.
//  3. PortIn=0x3C, load 0x1000_0004 -> 0x0000003C. Store to 0x1000_0004 -> PortOut and reads unchanged.
//     With _SYNC_EN, a PortIn change less than 2 cycles before RESP is not yet visible.
//  4. MEMORY_DEPTH=1024: store 0x11 to 0x0000_1004 -> load 0x0000_0004 returns 0x11 (wrap).
//  5. req_valid held high continuously -> resp_valid every 2+WAIT_STATES cycles, never back-to-back.
//     WAIT_STATES=0 -> resp_valid at T+1.
//  6. Assert reset during WAIT of a store to PortOut -> resp_valid never pulses, PortOut=0,
//     FSM IDLE, next request served normally.

Source files
------------

// File: rtl/mips_dmem_responder.sv
// rtl/mips_dmem_responder.sv - load/store responder with wait states, word RAM and PortOut/PortIn I/O window (option: MIPS_DMEM_PORTIN_SYNC_EN)
module mips_dmem_responder #(
    parameter int MEMORY_DEPTH = 1024,
    parameter int WAIT_STATES  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        stall,
    input  logic [7:0]  PortIn,
    output logic [31:0] PortOut
);

    localparam int AW = $clog2(MEMORY_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        write_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic [31:0] portout_q;

    logic [31:0] mem [MEMORY_DEPTH];

    logic [7:0]  portin_s;

`ifdef MIPS_DMEM_PORTIN_SYNC_EN
    logic [7:0]  sync1_q;
    logic [7:0]  sync2_q;

    // Two-flop synchronizer for the asynchronous board pins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 8'h00;
            sync2_q <= 8'h00;
        end else begin
            sync1_q <= PortIn;
            sync2_q <= sync1_q;
        end
    end
    assign portin_s = sync2_q;
`else
    assign portin_s = PortIn;
`endif

    // In IDLE the request is being accepted this edge, so decode the live bus;
    // afterwards decode the latched copy.
    logic [31:0]   cur_addr;
    logic [31:0]   cur_wdata;
    logic          cur_write;
    logic          is_io;
    logic [25:0]   io_off;
    logic [AW-1:0] idx;
    logic          enter_resp;
    logic          ram_we;
    logic [31:0]   load_data;
    logic          unused_bits;

    assign cur_addr    = (state_q == S_IDLE) ? req_addr  : addr_q;
    assign cur_wdata   = (state_q == S_IDLE) ? req_wdata : wdata_q;
    assign cur_write   = (state_q == S_IDLE) ? req_write : write_q;
    assign is_io       = (cur_addr[31:28] == 4'h1);
    assign io_off      = cur_addr[27:2];
    assign idx         = cur_addr[AW+1:2];
    assign unused_bits = ^cur_addr[1:0];

    assign enter_resp = ((state_q == S_IDLE) && req_valid && (WAIT_STATES == 0)) ||
                        ((state_q == S_WAIT) && (cnt_q == 4'd1));
    assign ram_we     = enter_resp && cur_write && !is_io;

    // Read mux over RAM and the I/O window
    always_comb begin
        load_data = 32'h0;
        if (is_io) begin
            if (io_off == 26'd0)      load_data = portout_q;
            else if (io_off == 26'd1) load_data = {24'h0, portin_s};
        end else begin
            load_data = mem[idx];
        end
    end

    // Word RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (ram_we) mem[idx] <= cur_wdata;
    end

    // Request FSM with registered response and PortOut register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            write_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            portout_q    <= 32'h0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        write_q <= req_write;
                        cnt_q   <= 4'(WAIT_STATES);
                        state_q <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_q <= S_RESP;
                end
                default: state_q <= S_IDLE;
            endcase
            if (enter_resp) begin
                resp_valid_q <= 1'b1;
                if (cur_write) begin
                    resp_rdata_q <= 32'h0;
                    if (is_io && (io_off == 26'd0)) portout_q <= cur_wdata;
                end else begin
                    resp_rdata_q <= load_data;
                end
            end
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign PortOut    = portout_q;
    assign stall      = req_valid & ~resp_valid_q;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// tb/tb_mips_dmem_responder.sv - directed bench for mips_dmem_responder (WAIT_STATES=2 and 0 instances)
module tb_mips_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        rv [2];
    logic        rw [2];
    logic [31:0] ra [2];
    logic [31:0] rwd [2];
    logic        rsv [2];
    logic [31:0] rrd [2];
    logic        st [2];
    logic [31:0] po [2];
    logic [7:0]  pin;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mips_dmem_responder #(.MEMORY_DEPTH(1024), .WAIT_STATES(2)) dut (
        .clk(clk), .reset(reset), .req_valid(rv[0]), .req_write(rw[0]),
        .req_addr(ra[0]), .req_wdata(rwd[0]), .resp_valid(rsv[0]), .resp_rdata(rrd[0]),
        .stall(st[0]), .PortIn(pin), .PortOut(po[0])
    );

    mips_dmem_responder #(.MEMORY_DEPTH(1024), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(rv[1]), .req_write(rw[1]),
        .req_addr(ra[1]), .req_wdata(rwd[1]), .resp_valid(rsv[1]), .resp_rdata(rrd[1]),
        .stall(st[1]), .PortIn(pin), .PortOut(po[1])
    );

    // One request; returns data, cycles before resp, stall errors and PortOut in the RESP cycle
    task automatic do_req(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output int lat, output int serr,
                          output logic [31:0] po_rsp);
        @(posedge clk); #1;
        rv[s] = 1'b1; rw[s] = w; ra[s] = a; rwd[s] = d;
        lat = 0; serr = 0; rd = 32'hx; po_rsp = 32'hx;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsv[s] === 1'b1) begin
                rd = rrd[s]; po_rsp = po[s];
                if (st[s] !== 1'b0) serr++;
                break;
            end
            if (st[s] !== 1'b1) serr++;
            lat++;
        end
        @(posedge clk); #1;
        rv[s] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; pin = 8'h00;
        for (int s = 0; s < 2; s++) begin rv[s] = 0; rw[s] = 0; ra[s] = 0; rwd[s] = 0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (rsv[0] !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b exp=0", rsv[0]); end
        total++; if (rrd[0] !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rrd[0]); end
        total++; if (po[0] !== 32'h0) begin bad++; $display("FAIL reset_portout got=%h exp=0", po[0]); end
        total++; if (st[0] !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", st[0]); end
        reset = 1'b0;
    endtask

    task automatic test_ram();
        logic [31:0] rd, p; int lat, se;
        do_req(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, rd, lat, se, p);
        total++; if (lat !== 3) begin bad++; $display("FAIL store_latency got=%0d exp=3", lat); end
        total++; if (se !== 0) begin bad++; $display("FAIL store_stall errors=%0d exp=0", se); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL store_rdata got=%h exp=0", rd); end
        do_req(0, 1'b0, 32'h0000_0010, 32'h0, rd, lat, se, p);
        total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL load_ram got=%h exp=deadbeef", rd); end
        total++; if (lat !== 3) begin bad++; $display("FAIL load_latency got=%0d exp=3", lat); end
    endtask

    task automatic test_portout();
        logic [31:0] rd, p; int lat, se;
        do_req(0, 1'b1, 32'h1000_0000, 32'h0000_00A5, rd, lat, se, p);
        total++; if (p !== 32'hA5) begin bad++; $display("FAIL portout_at_resp got=%h exp=a5", p); end
        do_req(0, 1'b0, 32'h1000_0000, 32'h0, rd, lat, se, p);
        total++; if (rd !== 32'hA5) begin bad++; $display("FAIL load_portout got=%h exp=a5", rd); end
    endtask

    task automatic test_portin();
        logic [31:0] rd, p; int lat, se;
        pin = 8'h3C;
        do_req(0, 1'b0, 32'h1000_0004, 32'h0, rd, lat, se, p);
        total++; if (rd !== 32'h3C) begin bad++; $display("FAIL load_portin got=%h exp=3c", rd); end
        do_req(0, 1'b1, 32'h1000_0004, 32'hFFFF_FFFF, rd, lat, se, p);
        total++; if (po[0] !== 32'hA5) begin bad++; $display("FAIL portin_store_portout got=%h exp=a5", po[0]); end
        do_req(0, 1'b0, 32'h1000_0004, 32'h0, rd, lat, se, p);
        total++; if (rd !== 32'h3C) begin bad++; $display("FAIL portin_after_store got=%h exp=3c", rd); end
        do_req(0, 1'b0, 32'h1000_0008, 32'h0, rd, lat, se, p);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL io_other_offset got=%h exp=0", rd); end
    endtask

    task automatic test_wrap();
        logic [31:0] rd, p; int lat, se;
        do_req(0, 1'b1, 32'h0000_1004, 32'h0000_0011, rd, lat, se, p);
        do_req(0, 1'b0, 32'h0000_0004, 32'h0, rd, lat, se, p);
        total++; if (rd !== 32'h11) begin bad++; $display("FAIL ram_wrap got=%h exp=11", rd); end
        do_req(0, 1'b0, 32'h0000_0010, 32'h0, rd, lat, se, p);
        total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wrap_no_alias got=%h exp=deadbeef", rd); end
    endtask

    // req_valid held high: responses every per cycles, first one per-1 cycles in
    task automatic test_back_to_back(input int s, input int per);
        int n = 0; int first = -1; int last = -1; int gerr = 0;
        @(posedge clk); #1;
        rv[s] = 1'b1; rw[s] = 1'b0; ra[s] = 32'h0000_0010;
        for (int i = 0; i < 4 * per; i++) begin
            @(negedge clk);
            if (rsv[s] === 1'b1) begin
                if (first < 0) first = i;
                if (last >= 0 && (i - last) != per) gerr++;
                last = i; n++;
            end
        end
        @(posedge clk); #1;
        rv[s] = 1'b0;
        total++; if (first !== per - 1) begin bad++; $display("FAIL b2b_first_%0d got=%0d exp=%0d", s, first, per - 1); end
        total++; if (n !== 4) begin bad++; $display("FAIL b2b_count_%0d got=%0d exp=4", s, n); end
        total++; if (gerr !== 0) begin bad++; $display("FAIL b2b_gap_%0d errors=%0d exp=0", s, gerr); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd, p; int lat, se;
        do_req(1, 1'b1, 32'h0000_0020, 32'h1234_5678, rd, lat, se, p);
        total++; if (lat !== 1) begin bad++; $display("FAIL ws0_latency got=%0d exp=1", lat); end
        do_req(1, 1'b0, 32'h0000_0020, 32'h0, rd, lat, se, p);
        total++; if (rd !== 32'h1234_5678) begin bad++; $display("FAIL ws0_load got=%h exp=12345678", rd); end
        total++; if (se !== 0) begin bad++; $display("FAIL ws0_stall errors=%0d exp=0", se); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd, p; int lat, se; int pulses = 0;
        @(posedge clk); #1;
        rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 32'h1000_0000; rwd[0] = 32'h0000_0077;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1 rv[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin @(negedge clk); if (rsv[0] === 1'b1) pulses++; end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin @(negedge clk); if (rsv[0] === 1'b1) pulses++; end
        total++; if (pulses !== 0) begin bad++; $display("FAIL abort_resp_pulses got=%0d exp=0", pulses); end
        total++; if (po[0] !== 32'h0) begin bad++; $display("FAIL abort_portout got=%h exp=0", po[0]); end
        do_req(0, 1'b0, 32'h1000_0000, 32'h0, rd, lat, se, p);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL abort_load_portout got=%h exp=0", rd); end
        total++; if (lat !== 3) begin bad++; $display("FAIL abort_next_latency got=%0d exp=3", lat); end
        do_req(0, 1'b0, 32'h0000_0010, 32'h0, rd, lat, se, p);
        total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_kept_over_reset got=%h exp=deadbeef", rd); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_portout();
        test_portin();
        test_wrap();
        test_back_to_back(0, 4);
        test_zero_wait();
        test_back_to_back(1, 2);
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
